// File: rtl/actuator_interlock.sv
// Safety interlock between the sequencer and the physical actuator drivers.
// Blocks conflicting requests, adds motor dead-time, times out the fill valve.
module actuator_interlock #(
  parameter int DEAD_CYCLES  = 16,
  parameter int CNT_WIDTH    = 8,
  parameter int FILL_TIMEOUT = 1000,
  parameter int TO_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctrl_fill,
  input  logic       ctrl_release,
  input  logic       ctrl_forward,
  input  logic       ctrl_reverse,
  input  logic       fault_clr,
  output logic       drv_valve_in,
  output logic       drv_valve_out,
  output logic       drv_motor_fwd,
  output logic       drv_motor_rev,
  output logic       motor_busy,
  output logic [2:0] fault
);

  typedef enum logic [1:0] {
    M_IDLE,
    M_FWD,
    M_REV,
    M_DEAD
  } mstate_t;

  localparam logic [CNT_WIDTH-1:0] DEAD_LOAD =
    CNT_WIDTH'(DEAD_CYCLES - 1);
  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(FILL_TIMEOUT - 1);

  mstate_t              state;
  mstate_t              state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic [TO_WIDTH-1:0]  to_cnt;
  logic                 lockout;
  logic                 want_fwd;
  logic                 want_rev;
  logic                 timeout;
  logic [2:0]           fault_set;

  assign want_fwd = ctrl_forward & ~ctrl_reverse;
  assign want_rev = ctrl_reverse & ~ctrl_forward;
  assign timeout  = drv_valve_in & (to_cnt == TO_LAST);

  assign fault_set = {
    timeout,
    ctrl_fill & ctrl_release,
    ctrl_forward & ctrl_reverse
  };

  // Motor state and dead-time counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= M_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Motor next-state: every stop or reversal passes through M_DEAD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      M_IDLE: begin
        if (want_fwd)      state_nxt = M_FWD;
        else if (want_rev) state_nxt = M_REV;
      end
      M_FWD: begin
        if (!want_fwd) begin
          state_nxt = M_DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
      M_REV: begin
        if (!want_rev) begin
          state_nxt = M_DEAD;
          cnt_nxt   = DEAD_LOAD;
        end
      end
      M_DEAD: begin
        if (cnt == '0) begin
          if (want_fwd)      state_nxt = M_FWD;
          else if (want_rev) state_nxt = M_REV;
          else               state_nxt = M_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = M_IDLE;
    endcase
  end

  // Motor drives decode straight from the state flops.
  assign drv_motor_fwd = (state == M_FWD);
  assign drv_motor_rev = (state == M_REV);
  assign motor_busy    = (state != M_IDLE);

  // Valve drives, fill timeout, lockout and sticky faults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drv_valve_in  <= 1'b0;
      drv_valve_out <= 1'b0;
      to_cnt        <= '0;
      lockout       <= 1'b0;
      fault         <= '0;
    end else begin
      drv_valve_out <= ctrl_release & ~ctrl_fill;
      drv_valve_in  <= ctrl_fill & ~ctrl_release
                       & ~lockout & ~timeout;
      to_cnt        <= drv_valve_in ? to_cnt + 1'b1 : '0;
      if (!ctrl_fill)   lockout <= 1'b0;
      else if (timeout) lockout <= 1'b1;
      fault <= (fault & ~{3{fault_clr}}) | fault_set;
    end
  end

endmodule

// File: tb/tb_actuator_interlock.sv
// Randomised scoreboard bench for actuator_interlock.
// A cycle-level behavioural model predicts every output vector.
module tb_actuator_interlock;

  localparam int DEAD = 16;
  localparam int FT   = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctrl_fill;
  logic       ctrl_release;
  logic       ctrl_forward;
  logic       ctrl_reverse;
  logic       fault_clr;
  logic       drv_valve_in;
  logic       drv_valve_out;
  logic       drv_motor_fwd;
  logic       drv_motor_rev;
  logic       motor_busy;
  logic [2:0] fault;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  actuator_interlock #(
    .DEAD_CYCLES (DEAD),
    .CNT_WIDTH   (8),
    .FILL_TIMEOUT(FT),
    .TO_WIDTH    (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl_fill    (ctrl_fill),
    .ctrl_release (ctrl_release),
    .ctrl_forward (ctrl_forward),
    .ctrl_reverse (ctrl_reverse),
    .fault_clr    (fault_clr),
    .drv_valve_in (drv_valve_in),
    .drv_valve_out(drv_valve_out),
    .drv_motor_fwd(drv_motor_fwd),
    .drv_motor_rev(drv_motor_rev),
    .motor_busy   (motor_busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {drv_valve_in, drv_valve_out, drv_motor_fwd,
            drv_motor_rev, motor_busy, fault};
  endfunction

  // Reference model: dir 0 none/1 fwd/2 rev, dead_left = dead cycles
  // still to be shown, run = cycles the inlet has been open so far.
  int         m_dir;
  int         m_dead;
  int         m_run;
  bit         m_lock;
  bit         m_vin;
  bit         m_vout;
  logic [2:0] m_flt;

  initial begin
    int  want;
    bit  to;
    bit  nvin;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_dir = 0; m_dead = 0; m_run = 0;
        m_lock = 0; m_vin = 0; m_vout = 0; m_flt = 3'b000;
      end else begin
        want = (ctrl_forward && !ctrl_reverse) ? 1 :
               (ctrl_reverse && !ctrl_forward) ? 2 : 0;
        if (m_dead > 0) begin
          if (m_dead == 1) begin
            m_dead = 0;
            m_dir  = want;
          end else begin
            m_dead = m_dead - 1;
          end
        end else if (m_dir != 0 && want != m_dir) begin
          m_dir  = 0;
          m_dead = DEAD;
        end else if (m_dir == 0) begin
          m_dir = want;
        end
        to   = m_vin && (m_run == FT);
        nvin = ctrl_fill && !ctrl_release && !m_lock && !to;
        if (!ctrl_fill) m_lock = 0;
        else if (to)    m_lock = 1;
        m_run  = nvin ? m_run + 1 : 0;
        m_vin  = nvin;
        m_vout = ctrl_release && !ctrl_fill;
        m_flt  = (fault_clr ? 3'b000 : m_flt) |
                 {to, ctrl_fill && ctrl_release,
                  ctrl_forward && ctrl_reverse};
      end
      exp_q.push_back({m_vin, m_vout, m_dir == 1, m_dir == 2,
                       (m_dir != 0) || (m_dead > 0), m_flt});
    end
  end

  // Monitor: one output vector per clock, compared against the queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (outs() !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got=%b want=%b (vin vout fwd rev busy fault)",
                   $time, outs(), e);
        end
      end
    end
  end

  task automatic set_in(input bit f, input bit r,
                        input bit fw, input bit rv, input bit c);
    ctrl_fill    = f;
    ctrl_release = r;
    ctrl_forward = fw;
    ctrl_reverse = rv;
    fault_clr    = c;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Asynchronous reset between edges: drives must drop at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%b want=00000000", outs());
    end
    hold(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0);
    hold(3);
    rst_n = 1'b1;
    // Forward run, then reversal through dead-time.
    set_in(0, 0, 1, 0, 0); hold(5);
    set_in(0, 0, 0, 1, 0); hold(25);
    set_in(0, 0, 0, 0, 0); hold(20);
    // Motor conflict, then clear with conflict removed.
    set_in(0, 0, 1, 1, 0); hold(3);
    set_in(0, 0, 0, 0, 1); hold(1);
    set_in(0, 0, 0, 0, 0); hold(2);
    // Fill timeout and lockout release.
    set_in(1, 0, 0, 0, 0); hold(15);
    set_in(0, 0, 0, 0, 0); hold(1);
    set_in(1, 0, 0, 0, 0); hold(5);
    set_in(0, 0, 0, 0, 0); hold(2);
    // Valve conflict with simultaneous clear.
    set_in(1, 1, 0, 0, 1); hold(1);
    set_in(0, 0, 0, 0, 0); hold(2);
    set_in(0, 0, 0, 0, 1); hold(1);
    set_in(0, 0, 0, 0, 0); hold(1);
    // Reset in the middle of reverse and fill.
    set_in(1, 0, 0, 1, 0); hold(5);
    async_reset();
    set_in(0, 0, 1, 0, 0); hold(4);
    set_in(0, 0, 0, 0, 0); hold(20);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ctrl_fill    = ~ctrl_fill;
      if ($urandom_range(7) == 0) ctrl_release = ~ctrl_release;
      if ($urandom_range(5) == 0) ctrl_forward = ~ctrl_forward;
      if ($urandom_range(5) == 0) ctrl_reverse = ~ctrl_reverse;
      fault_clr = ($urandom_range(15) == 0);
      if ($urandom_range(399) == 0) async_reset();
      else hold(1);
    end
    set_in(0, 0, 0, 0, 0);
    hold(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
